// File: rtl/gshare_pht_sched_if.sv
// -----------------------------------------------------------------------------
// gshare_pht_sched_if
// Bundles the three buses that meet at the gshare PHT scheduler:
//   - commit-side update handshake  (upd_valid/upd_ready/upd_pc/upd_taken)
//   - fetch-side lookup             (pred_req/pred_pc/pred_gnt/pred_valid/pred_taken)
//   - single-port PHT SRAM access   (pht_en/pht_we/pht_addr/pht_wdata/pht_rdata)
// The scheduler connects through the slave modport; the environment (fetch,
// commit and the SRAM macro) connects through the master modport.
// Parameter:
//   PHT_IDX  PHT index width, must match the scheduler's PHT_IDX
// -----------------------------------------------------------------------------
interface gshare_pht_sched_if #(
  parameter int PHT_IDX = 8
);
  logic               upd_valid;
  logic               upd_ready;
  logic [31:0]        upd_pc;
  logic               upd_taken;

  logic               pred_req;
  logic [31:0]        pred_pc;
  logic               pred_gnt;
  logic               pred_valid;
  logic               pred_taken;

  logic               pht_en;
  logic               pht_we;
  logic [PHT_IDX-1:0] pht_addr;
  logic [1:0]         pht_wdata;
  logic [1:0]         pht_rdata;

  modport slave (
    input  upd_valid, upd_pc, upd_taken, pred_req, pred_pc, pht_rdata,
    output upd_ready, pred_gnt, pred_valid, pred_taken,
           pht_en, pht_we, pht_addr, pht_wdata
  );

  modport master (
    output upd_valid, upd_pc, upd_taken, pred_req, pred_pc, pht_rdata,
    input  upd_ready, pred_gnt, pred_valid, pred_taken,
           pht_en, pht_we, pht_addr, pht_wdata
  );
endinterface

// File: rtl/gshare_pht_sched.sv
// -----------------------------------------------------------------------------
// gshare_pht_sched
// Arbitrates the single-port, 1-cycle-read PHT SRAM between fetch lookups and
// queued commit-time counter updates. Sweeps the table to weakly-not-taken
// after reset or bp_clear, owns the committed global history register, and
// performs saturating 2-bit read-modify-write updates (read in RUN, write in
// UPD_WR on the following cycle).
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   bp_clear_i   soft re-init: drop queue, clear GHR, re-sweep the PHT
//   bus          slave side of gshare_pht_sched_if (update, lookup, SRAM)
//   ghr_o        committed global history
//   init_done_o  high once the table sweep has finished
// -----------------------------------------------------------------------------
module gshare_pht_sched #(
  parameter int PHT_IDX    = 8,
  parameter int GHR_DEPTH  = 8,
  parameter int UPDQ_DEPTH = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bp_clear_i,
  gshare_pht_sched_if.slave    bus,
  output logic [GHR_DEPTH-1:0] ghr_o,
  output logic                 init_done_o
);

  localparam int QW = $clog2(UPDQ_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_UPD_WR = 2'd2
  } state_e;

  typedef struct packed {
    logic [PHT_IDX-1:0] idx;
    logic               taken;
  } upd_t;

  state_e             state_q;
  logic [PHT_IDX-1:0] sweep_q;
  logic [GHR_DEPTH-1:0] ghr_q;
  logic [QW:0]        wr_ptr_q;
  logic [QW:0]        rd_ptr_q;
  logic [SW-1:0]      starve_q;
  upd_t               cur_q;
  logic               pred_valid_q;
  upd_t               q_mem [UPDQ_DEPTH];

  logic               q_empty;
  logic               q_full;
  upd_t               q_head;
  logic               in_run;
  logic               upd_urgent;
  logic               pred_gnt;
  logic               upd_rd;
  logic               push;
  logic               upd_ready;
  logic [PHT_IDX-1:0] pred_idx;
  logic [PHT_IDX-1:0] upd_idx;
  logic [1:0]         sat_d;
  logic               pht_en_d;
  logic               pht_we_d;
  logic [PHT_IDX-1:0] pht_addr_d;
  logic [1:0]         pht_wdata_d;

  // Only PC bits [PHT_IDX+1:2] participate in the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[31:PHT_IDX+2], bus.pred_pc[1:0],
                            bus.upd_pc[31:PHT_IDX+2],  bus.upd_pc[1:0]};

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[QW] != rd_ptr_q[QW]) &&
                   (wr_ptr_q[QW-1:0] == rd_ptr_q[QW-1:0]);
  assign q_head  = q_mem[rd_ptr_q[QW-1:0]];

  assign init_done_o = (state_q != S_INIT);
  assign upd_ready   = init_done_o & ~q_full;
  assign push        = bus.upd_valid & upd_ready;

  // Both hashes use the committed GHR as it stands this cycle, so a same-cycle
  // enqueue never influences a same-cycle lookup.
  assign pred_idx = ghr_q[PHT_IDX-1:0] ^ bus.pred_pc[PHT_IDX+1:2];
  assign upd_idx  = ghr_q[PHT_IDX-1:0] ^ bus.upd_pc[PHT_IDX+1:2];

  // Port priority inside RUN: forced update read, then lookup, then idle read.
  assign in_run     = (state_q == S_RUN);
  assign upd_urgent = in_run && !q_empty && (q_full || starve_q == SW'(STARVE_MAX));
  assign pred_gnt   = in_run && bus.pred_req && !upd_urgent;
  assign upd_rd     = upd_urgent || (in_run && !bus.pred_req && !q_empty);

  // Saturating step of the counter read on the previous cycle.
  always_comb begin
    sat_d = bus.pht_rdata;
    if (cur_q.taken) begin
      if (bus.pht_rdata != 2'b11) sat_d = bus.pht_rdata + 2'd1;
    end else begin
      if (bus.pht_rdata != 2'b00) sat_d = bus.pht_rdata - 2'd1;
    end
  end

  // NOTE: every output of this block gets a default before the case so that no
  // path leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    pht_en_d    = 1'b0;
    pht_we_d    = 1'b0;
    pht_addr_d  = '0;
    pht_wdata_d = 2'b00;
    case (state_q)
      S_INIT: begin
        pht_en_d    = 1'b1;
        pht_we_d    = 1'b1;
        pht_addr_d  = sweep_q;
        pht_wdata_d = 2'b01;
      end
      S_RUN: begin
        if (pred_gnt) begin
          pht_en_d   = 1'b1;
          pht_addr_d = pred_idx;
        end else if (upd_rd) begin
          pht_en_d   = 1'b1;
          pht_addr_d = q_head.idx;
        end
      end
      S_UPD_WR: begin
        // An abandoned read-modify-write must not reach the table.
        if (!bp_clear_i) begin
          pht_en_d    = 1'b1;
          pht_we_d    = 1'b1;
          pht_addr_d  = cur_q.idx;
          pht_wdata_d = sat_d;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the queue storage has no reset; the pointers alone define which
  // entries are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q[QW-1:0]] <= '{idx: upd_idx, taken: bus.upd_taken};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      ghr_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      starve_q     <= '0;
      cur_q        <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      // A grant issued in the bp_clear cycle still returns its data.
      pred_valid_q <= pred_gnt;
      if (bp_clear_i) begin
        state_q  <= S_INIT;
        sweep_q  <= '0;
        ghr_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        starve_q <= '0;
      end else begin
        if (push) begin
          ghr_q    <= {ghr_q[GHR_DEPTH-2:0], bus.upd_taken};
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (upd_rd) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          cur_q    <= q_head;
          starve_q <= '0;
        end else if (pred_gnt && !q_empty && starve_q != SW'(STARVE_MAX)) begin
          starve_q <= starve_q + 1'b1;
        end
        case (state_q)
          S_INIT: begin
            sweep_q <= sweep_q + 1'b1;
            if (sweep_q == '1) state_q <= S_RUN;
          end
          S_RUN:    if (upd_rd) state_q <= S_UPD_WR;
          S_UPD_WR: state_q <= S_RUN;
          default:  state_q <= S_INIT;
        endcase
      end
    end
  end

  assign bus.upd_ready  = upd_ready;
  assign bus.pred_gnt   = pred_gnt;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_valid_q & bus.pht_rdata[1];
  assign bus.pht_en     = pht_en_d;
  assign bus.pht_we     = pht_we_d;
  assign bus.pht_addr   = pht_addr_d;
  assign bus.pht_wdata  = pht_wdata_d;
  assign ghr_o          = ghr_q;

endmodule

// File: tb/tb_gshare_pht_sched.sv
// -----------------------------------------------------------------------------
// tb_gshare_pht_sched
// Directed and randomized stimulus for gshare_pht_sched with PHT_IDX=4. The
// PHT SRAM is modelled here as a plain array; the reference keeps the counter
// table and history as integers and applies each accepted update in order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gshare_pht_sched;
  localparam int PHT_IDX    = 4;
  localparam int GHR_DEPTH  = 8;
  localparam int UPDQ_DEPTH = 4;
  localparam int STARVE_MAX = 7;
  localparam int DEPTH      = 1 << PHT_IDX;
  localparam int GHR_MOD    = 1 << GHR_DEPTH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 bp_clear = 1'b0;
  logic [GHR_DEPTH-1:0] ghr;
  logic                 init_done;

  gshare_pht_sched_if #(.PHT_IDX(PHT_IDX)) bus ();

  gshare_pht_sched #(
    .PHT_IDX(PHT_IDX), .GHR_DEPTH(GHR_DEPTH),
    .UPDQ_DEPTH(UPDQ_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst), .bp_clear_i(bp_clear),
    .bus(bus.slave), .ghr_o(ghr), .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with one-cycle read latency.
  logic [1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.pht_en) begin
      if (bus.pht_we) mem[bus.pht_addr] <= bus.pht_wdata;
      else            bus.pht_rdata     <= mem[bus.pht_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference state.
  int m_ghr;
  int m_pht [DEPTH];
  bit pend;
  logic exp_taken;

  // Per-cycle samples and access counters.
  logic s_gnt, s_rdy, s_en, s_we;
  logic [PHT_IDX-1:0] s_addr;
  int n_acc, n_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int g, input logic [31:0] pc);
    int unsigned p;
    p = pc / 4;
    return (g % DEPTH) ^ int'(p % DEPTH);
  endfunction

  function automatic logic [31:0] pc_for(input int g, input int tgt);
    return 32'(((g % DEPTH) ^ tgt) * 4);
  endfunction

  task automatic cmp_table(input string tag);
    for (int i = 0; i < DEPTH; i++) check(tag, 32'(mem[i]), 32'(m_pht[i]));
  endtask

  // One clock cycle: sample outputs, check lookups, advance the reference.
  task automatic step();
    int e;
    #1;
    s_gnt  = bus.pred_gnt;
    s_rdy  = bus.upd_ready;
    s_en   = bus.pht_en;
    s_we   = bus.pht_we;
    s_addr = bus.pht_addr;
    if (s_en) n_acc++;
    if (s_en && s_we) n_wr++;
    check("pred_valid", 32'(bus.pred_valid), 32'(pend));
    if (pend) check("pred_taken", 32'(bus.pred_taken), 32'(exp_taken));
    pend = 1'b0;
    if (s_gnt) begin
      e = idx_of(m_ghr, bus.pred_pc);
      check("gnt_access", 32'({s_en, s_we, s_addr}), 32'({1'b1, 1'b0, PHT_IDX'(e)}));
      pend      = 1'b1;
      exp_taken = mem[e][1];
    end
    if (bus.upd_valid && s_rdy) begin
      e = idx_of(m_ghr, bus.upd_pc);
      if (bus.upd_taken) m_pht[e] = (m_pht[e] == 3) ? 3 : m_pht[e] + 1;
      else               m_pht[e] = (m_pht[e] == 0) ? 0 : m_pht[e] - 1;
      m_ghr = (m_ghr * 2 + int'(bus.upd_taken)) % GHR_MOD;
    end
    if (bp_clear) begin
      m_ghr = 0;
      for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_checks(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check(tag, 32'({init_done, bus.pred_gnt, bus.upd_ready, bus.pht_en, bus.pht_we,
                      bus.pht_wdata, bus.pht_addr}),
                 32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, PHT_IDX'(i)}));
      step();
    end
  endtask

  task automatic send_upd(input int tgt, input logic taken);
    bus.upd_pc    = pc_for(m_ghr, tgt);
    bus.upd_taken = taken;
    bus.upd_valid = 1'b1;
    step();
    bus.upd_valid = 1'b0;
    check("send_ready", 32'(s_rdy), 32'd1);
    step(); step(); step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int ngnt;
    int last_idx;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.pred_req = 1'b0;  bus.pred_pc = '0;
    m_ghr = 0;
    pend  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 2'b10; m_pht[i] = 2; end

    // Reset with a pending lookup request: nothing may be granted.
    rst = 1'b0;
    bus.pred_req = 1'b1;
    @(posedge clk); #1;
    step();
    #1;
    check("rst_outs", 32'({init_done, bus.upd_ready, bus.pred_gnt, bus.pred_valid, bus.pred_taken}), 32'd0);
    check("rst_ghr", 32'(ghr), 32'd0);

    // Sweep: one 2'b01 write per cycle to addr 0..15, then init_done.
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    sweep_checks("sweep");
    bus.pred_req = 1'b0;
    #1;
    check("init_done", 32'(init_done), 32'd1);
    check("init_ghr", 32'(ghr), 32'd0);
    cmp_table("init_table");
    step();

    // First lookup: pc 0x8, ghr 0 -> addr 2, weakly not-taken.
    bus.pred_pc = 32'h8; bus.pred_req = 1'b1;
    #1;
    check("pred_addr", 32'(bus.pht_addr), 32'd2);
    check("pred_gnt", 32'(bus.pred_gnt), 32'd1);
    step();
    bus.pred_req = 1'b0;
    #1;
    check("pred_valid1", 32'(bus.pred_valid), 32'd1);
    check("pred_taken1", 32'(bus.pred_taken), 32'd0);
    step();

    // Two taken updates at pc 0x10: idx 4 then 5, two port cycles each.
    n_acc = 0; n_wr = 0;
    bus.upd_pc = 32'h10; bus.upd_taken = 1'b1; bus.upd_valid = 1'b1;
    step(); step();
    bus.upd_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("two_upd_acc", 32'(n_acc), 32'd4);
    check("two_upd_wr", 32'(n_wr), 32'd2);
    check("pht4", 32'(mem[4]), 32'd2);
    check("pht5", 32'(mem[5]), 32'd2);
    check("ghr_11", 32'(ghr), 32'd3);

    // Saturation at both ends of the counter on idx 4.
    for (int k = 0; k < 4; k++) send_upd(4, 1'b1);
    check("sat_hi", 32'(mem[4]), 32'd3);
    for (int k = 0; k < 4; k++) send_upd(4, 1'b0);
    check("sat_lo", 32'(mem[4]), 32'd0);
    check("sat_ghr", 32'(ghr), 32'(m_ghr));

    // Starvation: lookups held high with one queued update.
    bus.pred_pc = 32'h40; bus.pred_req = 1'b1;
    last_idx = 9;
    bus.upd_pc = pc_for(m_ghr, last_idx); bus.upd_taken = 1'b1; bus.upd_valid = 1'b1;
    step();
    bus.upd_valid = 1'b0;
    check("starve_first_gnt", 32'(s_gnt), 32'd1);
    ngnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!s_gnt) break;
      ngnt++;
    end
    check("starve_gnts", 32'(ngnt), 32'd7);
    check("starve_read", 32'({s_gnt, s_en, s_we, s_addr}), 32'({1'b0, 1'b1, 1'b0, PHT_IDX'(last_idx)}));
    step();
    check("starve_wr_nognt", 32'({s_gnt, s_en, s_we, s_addr}), 32'({1'b0, 1'b1, 1'b1, PHT_IDX'(last_idx)}));
    step();
    check("starve_regnt", 32'(s_gnt), 32'd1);

    // Fill the queue while lookups keep winning, then the update preempts.
    for (int k = 0; k < UPDQ_DEPTH; k++) begin
      bus.upd_pc = $urandom; bus.upd_taken = 1'($urandom); bus.upd_valid = 1'b1;
      step();
      check("fill_gnt", 32'({s_gnt, s_rdy}), 32'b11);
    end
    bus.upd_valid = 1'b0;
    step();
    check("full_preempt", 32'({s_gnt, s_rdy, s_en, s_we}), 32'b0010);
    bus.pred_req = 1'b0;
    for (int i = 0; i < 12; i++) step();
    cmp_table("fill_table");
    check("fill_ghr", 32'(ghr), 32'(m_ghr));

    // bp_clear during UPD_WR: no write, queue dropped, history cleared, re-sweep.
    bus.upd_pc = $urandom; bus.upd_taken = 1'b1; bus.upd_valid = 1'b1;
    step();
    bus.upd_pc = $urandom;
    step();
    bus.upd_valid = 1'b0;
    check("clr_pre_read", 32'({s_en, s_we}), 32'b10);
    bp_clear = 1'b1;
    #1;
    check("clr_nowr", 32'({bus.pht_en, bus.pht_we}), 32'd0);
    step();
    bp_clear = 1'b0;
    check("clr_ghr", 32'(ghr), 32'd0);
    sweep_checks("resweep");
    n_acc = 0;
    for (int i = 0; i < 6; i++) step();
    check("clr_q_empty", 32'(n_acc), 32'd0);
    cmp_table("clr_table");

    // Randomized traffic with occasional soft clears.
    for (int c = 0; c < 800; c++) begin
      bus.pred_req  = 1'($urandom);
      bus.pred_pc   = $urandom;
      bus.upd_valid = ($urandom_range(0, 2) == 0);
      bus.upd_pc    = $urandom;
      bus.upd_taken = 1'($urandom);
      bp_clear      = ($urandom_range(0, 149) == 0);
      step();
    end
    bp_clear = 1'b0; bus.pred_req = 1'b0; bus.upd_valid = 1'b0;
    for (int i = 0; i < 40; i++) step();
    check("rand_init_done", 32'(init_done), 32'd1);
    check("rand_ghr", 32'(ghr), 32'(m_ghr));
    cmp_table("rand_table");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
